// File: rtl/axil_req_arbiter_if.sv
// Bus bundle for axil_req_arbiter: two-requester front end plus AXI4-Lite master port.
// The master modport is the arbiter's view; slave is the requesters/AXI slave view.
interface axil_req_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [1:0]              req_valid;
   logic [1:0]              req_write;
   logic [2*ADDR_WIDTH-1:0] req_addr;
   logic [2*DATA_WIDTH-1:0] req_wdata;
   logic [1:0]              req_ready;
   logic [1:0]              rsp_valid;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic [1:0]              rsp_resp;

   logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
   logic [2:0]              M_AXI_AWPROT;
   logic                    M_AXI_AWVALID;
   logic                    M_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
   logic                    M_AXI_WVALID;
   logic                    M_AXI_WREADY;
   logic [1:0]              M_AXI_BRESP;
   logic                    M_AXI_BVALID;
   logic                    M_AXI_BREADY;
   logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
   logic [2:0]              M_AXI_ARPROT;
   logic                    M_AXI_ARVALID;
   logic                    M_AXI_ARREADY;
   logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
   logic [1:0]              M_AXI_RRESP;
   logic                    M_AXI_RVALID;
   logic                    M_AXI_RREADY;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_resp,
      output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BRESP, M_AXI_BVALID,
      output M_AXI_BREADY,
      output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
      input  M_AXI_ARREADY,
      input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      output M_AXI_RREADY
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
      input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BRESP, M_AXI_BVALID,
      input  M_AXI_BREADY,
      input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
      output M_AXI_ARREADY,
      output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      input  M_AXI_RREADY
   );
endinterface

// File: rtl/axil_req_arbiter.sv
// Two-requester arbiter onto a single AXI4-Lite master, one transaction in flight.
// Define AXIL_ARB_STRICT_PRI_EN for fixed priority (requester 0 wins); default is round-robin.
module axil_req_arbiter #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic               ACLK,
   input  logic               ARESETN,
   axil_req_arbiter_if.master bus
);
   typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, DONE} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_gnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic [1:0]            r_resp;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rsp_valid;
   logic [1:0]            r_rsp_resp;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;

   logic                  w_gnt_idx;
   logic                  w_capture;
   logic                  w_sel_write;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic                  w_awvalid;
   logic                  w_wvalid;
   logic                  w_arvalid;
   logic                  w_bready;
   logic                  w_rready;
   logic                  w_aw_hs;
   logic                  w_w_hs;

`ifdef AXIL_ARB_STRICT_PRI_EN
   always_comb w_gnt_idx = ~bus.req_valid[0];
`else
   logic r_last;

   always_comb begin
      w_gnt_idx = bus.req_valid[1];
      if (&bus.req_valid) w_gnt_idx = ~r_last;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) r_last <= 1'b1;
      else if (w_capture) r_last <= w_gnt_idx;
   end
`endif

   // ARESETN gating keeps req_ready low while reset is held with requests pending
   assign w_capture   = (r_state == IDLE) && (|bus.req_valid) && ARESETN;
   assign w_sel_write = w_gnt_idx ? bus.req_write[1] : bus.req_write[0];
   assign w_sel_addr  = w_gnt_idx ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : bus.req_addr[ADDR_WIDTH-1:0];
   assign w_sel_wdata = w_gnt_idx ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : bus.req_wdata[DATA_WIDTH-1:0];
   assign w_aw_hs     = w_awvalid && bus.M_AXI_AWREADY;
   assign w_w_hs      = w_wvalid && bus.M_AXI_WREADY;

   always_comb begin
      w_state_nxt = r_state;
      w_awvalid   = (r_state == WR) && !r_aw_done;
      w_wvalid    = (r_state == WR) && !r_w_done;
      w_arvalid   = (r_state == RA);
      w_bready    = (r_state == WB);
      w_rready    = (r_state == RD);
      case (r_state)
         IDLE: if (w_capture) w_state_nxt = w_sel_write ? WR : RA;
         WR:   if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = WB;
         WB:   if (bus.M_AXI_BVALID) w_state_nxt = DONE;
         RA:   if (bus.M_AXI_ARREADY) w_state_nxt = RD;
         RD:   if (bus.M_AXI_RVALID) w_state_nxt = DONE;
         DONE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state     <= IDLE;
         r_gnt       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_resp      <= '0;
         r_rdata     <= '0;
         r_rsp_valid <= '0;
         r_rsp_resp  <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_gnt     <= w_gnt_idx;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs)  r_w_done  <= 1'b1;
         if (w_bready && bus.M_AXI_BVALID) begin
            r_resp  <= bus.M_AXI_BRESP;
            r_rdata <= '0;
         end
         if (w_rready && bus.M_AXI_RVALID) begin
            r_resp  <= bus.M_AXI_RRESP;
            r_rdata <= bus.M_AXI_RDATA;
         end
         // Response outputs are registered out of DONE and are zero between pulses
         r_rsp_valid <= (r_state == DONE) ? {r_gnt, ~r_gnt} : 2'b00;
         r_rsp_resp  <= (r_state == DONE) ? r_resp : 2'b00;
         r_rsp_rdata <= (r_state == DONE) ? r_rdata : '0;
      end
   end

   assign bus.req_ready     = w_capture ? {w_gnt_idx, ~w_gnt_idx} : 2'b00;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_resp      = r_rsp_resp;
   assign bus.rsp_rdata     = r_rsp_rdata;
   assign bus.M_AXI_AWADDR  = r_addr;
   assign bus.M_AXI_AWPROT  = 3'b000;
   assign bus.M_AXI_AWVALID = w_awvalid;
   assign bus.M_AXI_WDATA   = r_wdata;
   assign bus.M_AXI_WSTRB   = '1;
   assign bus.M_AXI_WVALID  = w_wvalid;
   assign bus.M_AXI_BREADY  = w_bready;
   assign bus.M_AXI_ARADDR  = r_addr;
   assign bus.M_AXI_ARPROT  = 3'b000;
   assign bus.M_AXI_ARVALID = w_arvalid;
   assign bus.M_AXI_RREADY  = w_rready;
endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter with a 4-word AXI4-Lite slave model
// that has programmable ready delays, forced RRESP and a B-response hold.
module tb_axil_req_arbiter;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;

   logic ACLK = 1'b0;
   logic ARESETN;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   g_cyc = 0;

   int         aw_delay = 0;
   int         w_delay = 0;
   int         ar_delay = 0;
   logic [1:0] rresp_val = 2'b00;
   logic       b_hold = 1'b0;

   int          aw_cnt, w_cnt, ar_cnt;
   logic        aw_got, w_got;
   logic [3:0]  aw_q;
   logic [31:0] wd_q;
   logic [31:0] mem [4];

   axil_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axil_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .bus     (bus)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt >= aw_delay);
   assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID && (w_cnt >= w_delay);
   assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (ar_cnt >= ar_delay);
   assign bus.M_AXI_BRESP   = 2'b00;

   // AXI4-Lite slave: B follows the cycle both AW and W are in, R follows AR
   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; aw_q <= '0; wd_q <= '0;
         bus.M_AXI_BVALID <= 1'b0;
         bus.M_AXI_RVALID <= 1'b0;
         bus.M_AXI_RDATA  <= '0;
         bus.M_AXI_RRESP  <= '0;
      end else begin
         aw_cnt <= (bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY) ? aw_cnt + 1 : 0;
         w_cnt  <= (bus.M_AXI_WVALID && !bus.M_AXI_WREADY) ? w_cnt + 1 : 0;
         ar_cnt <= (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY) ? ar_cnt + 1 : 0;
         if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
            aw_got <= 1'b1; aw_q <= bus.M_AXI_AWADDR;
         end
         if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
            w_got <= 1'b1; wd_q <= bus.M_AXI_WDATA;
         end
         if (((bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) || aw_got) &&
             ((bus.M_AXI_WVALID && bus.M_AXI_WREADY) || w_got) &&
             !bus.M_AXI_BVALID && !b_hold) begin
            mem[(bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) ? bus.M_AXI_AWADDR[3:2] : aw_q[3:2]]
               <= (bus.M_AXI_WVALID && bus.M_AXI_WREADY) ? bus.M_AXI_WDATA : wd_q;
            bus.M_AXI_BVALID <= 1'b1;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) bus.M_AXI_BVALID <= 1'b0;
         if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
            bus.M_AXI_RVALID <= 1'b1;
            bus.M_AXI_RDATA  <= mem[bus.M_AXI_ARADDR[3:2]];
            bus.M_AXI_RRESP  <= rresp_val;
         end else if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin
            bus.M_AXI_RVALID <= 1'b0;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Drives a request, waits for its grant, returns at posedge+1 of cycle +1
   task automatic start_req(input int n, input logic wr, input logic [3:0] addr, input logic [31:0] wd);
      int t = 0;
      bus.req_write[n] = wr;
      bus.req_addr[n*4 +: 4] = addr;
      bus.req_wdata[n*32 +: 32] = wd;
      bus.req_valid[n] = 1'b1;
      #1;
      while (bus.req_ready[n] !== 1'b1 && t < 50) begin
         @(posedge ACLK); #1; t++;
      end
      check_eq("req_ready", 32'(bus.req_ready), 32'(n == 0 ? 2'b01 : 2'b10));
      g_cyc = cyc;
      @(posedge ACLK); #1;
      bus.req_valid[n] = 1'b0;
      check_eq("ch_valid", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}),
               32'(wr ? 3'b110 : 3'b001));
      check_eq("axi_addr", 32'(wr ? bus.M_AXI_AWADDR : bus.M_AXI_ARADDR), 32'(addr));
      if (wr) check_eq("axi_wdata", bus.M_AXI_WDATA, wd);
   endtask

   task automatic finish_req(input int n, input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                             input int exp_lat);
      int t = 0;
      while (bus.rsp_valid === 2'b00 && t < 100) begin
         @(posedge ACLK); #1; t++;
      end
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(n == 0 ? 2'b01 : 2'b10));
      check_eq("latency", 32'(cyc - g_cyc), 32'(exp_lat));
      check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
      check_eq("rsp_resp", 32'(bus.rsp_resp), 32'(exp_resp));
      @(posedge ACLK); #1;
      check_eq("rsp_pulse", 32'(bus.rsp_valid), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_gnt [4];
      logic [2:0] skew_tab [4];
      int ng;
      int t;

      for (int unsigned i = 0; i < 4; i++) mem[i] = '0;
      ARESETN = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_write = 2'b11;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      repeat (2) @(posedge ACLK);
      #1;
      check_eq("rst_req_ready", 32'(bus.req_ready), 32'(0));
      check_eq("rst_handshake", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                    bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 32'(0));
      check_eq("rst_rsp", 32'({bus.rsp_valid, bus.rsp_resp}), 32'(0));
      check_eq("rst_rdata", bus.rsp_rdata, 32'h0);
      bus.req_valid = 2'b00;
      ARESETN = 1'b1;
      @(posedge ACLK); #1;

      // Single write then readback on requester 0
      start_req(0, 1'b1, 4'h0, 32'h0000_0001);
      check_eq("wstrb", 32'(bus.M_AXI_WSTRB), 32'hF);
      check_eq("awprot", 32'(bus.M_AXI_AWPROT), 32'(0));
      finish_req(0, 32'h0, 2'b00, 4);
      start_req(0, 1'b0, 4'h0, 32'h0);
      check_eq("arprot", 32'(bus.M_AXI_ARPROT), 32'(0));
      finish_req(0, 32'h0000_0001, 2'b00, 4);

      // Requester 1: four writes then four reads
      for (int unsigned i = 0; i < 4; i++) begin
         start_req(1, 1'b1, 4'(i * 4), 32'(i + 1));
         finish_req(1, 32'h0, 2'b00, 4);
      end
      for (int unsigned i = 0; i < 4; i++) begin
         start_req(1, 1'b0, 4'(i * 4), 32'h0);
         finish_req(1, 32'(i + 1), 2'b00, 4);
      end

      // Contention: r0 writes 0x4, r1 reads 0x8; last served was r1
`ifdef AXIL_ARB_STRICT_PRI_EN
      exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      bus.req_write = 2'b01;
      bus.req_addr = {4'h8, 4'h4};
      bus.req_wdata = {32'h0, 32'hCAFE_0004};
      bus.req_valid = 2'b11;
      #1;
      ng = 0;
      t = 0;
      while (ng < 4 && t < 200) begin
         if (bus.req_ready !== 2'b00) begin
            check_eq($sformatf("grant%0d", ng), 32'(bus.req_ready), 32'(exp_gnt[ng]));
            ng++;
         end
         if (bus.rsp_valid[1] === 1'b1) check_eq("cont_rdata", bus.rsp_rdata, 32'h3);
         @(posedge ACLK); #1;
         t++;
      end
      check_eq("cont_grants", 32'(ng), 32'(4));
      bus.req_valid = 2'b00;
      repeat (12) @(posedge ACLK);
      #1;

      // Channel skew: WREADY immediate, AWREADY three cycles later
      aw_delay = 3;
      skew_tab = '{3'b100, 3'b100, 3'b100, 3'b001};
      start_req(0, 1'b1, 4'hC, 32'h0000_0005);
      for (int k = 0; k < 4; k++) begin
         @(posedge ACLK); #1;
         check_eq($sformatf("skew_c%0d", k + 2),
                  32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY}), 32'(skew_tab[k]));
      end
      finish_req(0, 32'h0, 2'b00, 7);
      aw_delay = 0;

      // AR backpressure with SLVERR read response
      ar_delay = 5;
      rresp_val = 2'b10;
      start_req(1, 1'b0, 4'h4, 32'h0);
      for (int k = 2; k <= 6; k++) begin
         @(posedge ACLK); #1;
         check_eq($sformatf("ar_hold_c%0d", k), 32'({bus.M_AXI_ARVALID, bus.M_AXI_ARADDR}),
                  32'({1'b1, 4'h4}));
      end
      @(posedge ACLK); #1;
      check_eq("ar_to_rd", 32'({bus.M_AXI_ARVALID, bus.M_AXI_RREADY}), 32'(2'b01));
      finish_req(1, 32'hCAFE_0004, 2'b10, 9);
      ar_delay = 0;
      rresp_val = 2'b00;

      // Reset while waiting for B
      b_hold = 1'b1;
      start_req(0, 1'b1, 4'h8, 32'h0000_0077);
      t = 0;
      while (bus.M_AXI_BREADY !== 1'b1 && t < 20) begin
         @(posedge ACLK); #1; t++;
      end
      check_eq("bready_seen", 32'(bus.M_AXI_BREADY), 32'(1));
      #2;
      bus.req_write = 2'b01;
      bus.req_addr = {4'h8, 4'h8};
      bus.req_wdata = {32'h0, 32'h0000_0077};
      bus.req_valid = 2'b11;
      ARESETN = 1'b0;
      #1;
      check_eq("rst_mid_axi", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                  bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 32'(0));
      check_eq("rst_mid_req", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_resp}), 32'(0));
      check_eq("rst_mid_rdata", bus.rsp_rdata, 32'h0);
      b_hold = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge ACLK); #1;
         check_eq("rst_no_rsp", 32'(bus.rsp_valid), 32'(0));
      end
      ARESETN = 1'b1;
      #1;
      check_eq("post_rst_grant", 32'(bus.req_ready), 32'(2'b01));
      g_cyc = cyc;
      @(posedge ACLK); #1;
      bus.req_valid = 2'b00;
      finish_req(0, 32'h0, 2'b00, 4);
      start_req(1, 1'b0, 4'h8, 32'h0);
      finish_req(1, 32'h0000_0077, 2'b00, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
